// File: rtl/instr_fetch_seq.sv
// Instruction sequencer: byte-serial program load into a small word memory,
// then in-order issue of 16-bit instructions on a valid/ready interface.
module instr_fetch_seq #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    load_byte,
   input  logic          load_valid,
   input  logic          load_clr,
   input  logic          start,
   input  logic          stop,
   input  logic          loop_en,
   output logic [15:0]   instr_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [AW-1:0] pc,
   output logic [AW:0]   prog_len,
   output logic          busy,
   output logic          done,
   output logic          load_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [AW-1:0] PC_ZERO  = '0;
   localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);

   state_e         state_q, state_d;
   logic           phase_q, phase_d;
   logic [7:0]     held_q, held_d;
   logic [AW:0]    prog_len_q, prog_len_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [15:0]    instr_q, instr_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [15:0]    mem [DEPTH];
   logic           mem_we_s;
   logic [AW-1:0]  mem_waddr_s;
   logic [15:0]    mem_wdata_s;
   logic           xfer_s;
   logic           last_s;
   logic           full_s;
   logic [AW-1:0]  pc_inc_s;

   assign xfer_s   = valid_q & instr_ready;
   assign last_s   = ({1'b0, pc_q} == (prog_len_q - LEN_ONE));
   assign full_s   = (prog_len_q == LEN_FULL);
   assign pc_inc_s = pc_q + AW'(1);

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      held_d      = held_q;
      prog_len_d  = prog_len_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      err_d       = err_q;
      mem_we_s    = 1'b0;
      mem_waddr_s = prog_len_q[AW-1:0];
      mem_wdata_s = {load_byte, held_q};

      if (load_clr) begin
         state_d    = S_IDLE;
         prog_len_d = '0;
         phase_d    = 1'b0;
         err_d      = 1'b0;
         pc_d       = PC_ZERO;
         valid_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !stop) begin
                  // a half-loaded word is abandoned when execution begins
                  phase_d = 1'b0;
                  if (prog_len_q == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_RUN;
                     valid_d = 1'b1;
                     pc_d    = PC_ZERO;
                     instr_d = mem[PC_ZERO];
                  end
               end else if (load_valid) begin
                  if (full_s) begin
                     err_d = 1'b1;
                  end else if (!phase_q) begin
                     held_d  = load_byte;
                     phase_d = 1'b1;
                  end else begin
                     mem_we_s   = 1'b1;
                     prog_len_d = prog_len_q + LEN_ONE;
                     phase_d    = 1'b0;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               if (load_valid) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               if (stop) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  pc_d    = PC_ZERO;
               end else if (xfer_s) begin
                  if (!last_s) begin
                     pc_d    = pc_inc_s;
                     instr_d = mem[pc_inc_s];
                  end else if (loop_en) begin
                     pc_d    = PC_ZERO;
                     instr_d = mem[PC_ZERO];
                  end else begin
                     state_d = S_DONE;
                     valid_d = 1'b0;
                  end
               end else begin
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               if (load_valid) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               if (stop) begin
                  state_d = S_IDLE;
                  pc_d    = PC_ZERO;
               end else if (start && (prog_len_q != '0)) begin
                  state_d = S_RUN;
                  valid_d = 1'b1;
                  pc_d    = PC_ZERO;
                  instr_d = mem[PC_ZERO];
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         phase_q    <= 1'b0;
         held_q     <= 8'h00;
         prog_len_q <= '0;
         pc_q       <= PC_ZERO;
         instr_q    <= 16'h0000;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         held_q     <= held_d;
         prog_len_q <= prog_len_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Program storage; contents are not reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign prog_len    = prog_len_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign load_err    = err_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: stimulus pushes expected words from a
// behavioural program model, a monitor compares every presented instruction.
module tb_instr_fetch_seq;

   logic        clk, rst;
   logic [7:0]  load_byte;
   logic        load_valid, load_clr, start, stop, loop_en, instr_ready;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic [2:0]  pc;
   logic [3:0]  prog_len;
   logic        busy, done, load_err;

   instr_fetch_seq #(.DEPTH(8), .AW(3)) dut (
      .clk(clk), .rst(rst), .load_byte(load_byte), .load_valid(load_valid),
      .load_clr(load_clr), .start(start), .stop(stop), .loop_en(loop_en),
      .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc(pc), .prog_len(prog_len), .busy(busy), .done(done), .load_err(load_err)
   );

   typedef struct packed {
      logic [2:0]  pc;
      logic [15:0] w;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // behavioural model: program contents, length, byte phase, error, state (0 idle,1 run,2 done)
   logic [15:0] model_mem [8];
   int          model_len   = 0;
   int          model_phase = 0;
   logic [7:0]  model_held;
   logic        model_err   = 1'b0;
   int          model_state = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: the presented word must be the head of the expected queue
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && instr_valid) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_valid", {16'h0, instr_out}, 32'hFFFF_FFFF);
            end else begin
               chk("sb_instr", {16'h0, instr_out}, {16'h0, exp_q[0].w});
               chk("sb_pc", {29'h0, pc}, {29'h0, exp_q[0].pc});
               if (instr_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic load_b(input logic [7:0] b);
      load_byte  = b;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      if (model_state != 0 || model_len == 8) begin
         model_err = 1'b1;
      end else if (model_phase == 0) begin
         model_held  = b;
         model_phase = 1;
      end else begin
         model_mem[model_len] = {b, model_held};
         model_len++;
         model_phase = 0;
      end
   endtask

   task automatic load_word(input logic [15:0] w);
      load_b(w[7:0]);
      load_b(w[15:8]);
   endtask

   task automatic do_clr();
      load_clr = 1'b1;
      tick();
      load_clr = 1'b0;
      model_len = 0; model_phase = 0; model_err = 1'b0; model_state = 0;
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      model_state = 0;
   endtask

   // push n expected transfers (program order, wrapping), then pulse start
   task automatic begin_run(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc = 3'(i % model_len);
         e.w  = model_mem[i % model_len];
         exp_q.push_back(e);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      model_phase = 0;
      model_state = (model_len > 0) ? 1 : 2;
   endtask

   task automatic finish_run();
      for (int c = 0; c < 300 && !done; c++) begin
         instr_ready = 1'($urandom_range(0, 1));
         tick();
      end
      instr_ready = 1'b0;
      chk("run_done", {31'h0, done}, 32'h1);
      chk("sb_empty", exp_q.size(), 32'h0);
      model_state = 2;
   endtask

   initial begin
      int k;
      int cnt;
      logic x;
      logic stopped;
      rst = 1'b1; load_byte = 8'h00; load_valid = 1'b0; load_clr = 1'b0;
      start = 1'b0; stop = 1'b0; loop_en = 1'b0; instr_ready = 1'b0;
      repeat (3) tick();
      chk("rst_instr", {16'h0, instr_out}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_pc", {29'h0, pc}, 32'h0);
      chk("rst_len", {28'h0, prog_len}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, load_err}, 32'h0);
      rst = 1'b0;
      tick();

      // two-word program, ready high: back-to-back issue then DONE
      load_b(8'h03); load_b(8'h60); load_b(8'h3B); load_b(8'h2A);
      chk("len2", {28'h0, prog_len}, 32'h2);
      instr_ready = 1'b1;
      begin_run(2);
      chk("w0_valid", {31'h0, instr_valid}, 32'h1);
      chk("w0_instr", {16'h0, instr_out}, 32'h6003);
      chk("w0_busy", {31'h0, busy}, 32'h1);
      tick();
      chk("w1_valid", {31'h0, instr_valid}, 32'h1);
      chk("w1_instr", {16'h0, instr_out}, 32'h2A3B);
      tick();
      chk("p1_done", {31'h0, done}, 32'h1);
      chk("p1_valid", {31'h0, instr_valid}, 32'h0);
      instr_ready = 1'b0;
      model_state = 2;

      // rerun from DONE with three stall cycles
      begin_run(2);
      for (int i = 0; i < 3; i++) begin
         chk("stall_pc", {29'h0, pc}, 32'h0);
         chk("stall_instr", {16'h0, instr_out}, 32'h6003);
         tick();
      end
      instr_ready = 1'b1;
      tick();
      chk("stall_adv_pc", {29'h0, pc}, 32'h1);
      tick();
      chk("stall_done", {31'h0, done}, 32'h1);
      instr_ready = 1'b0;
      model_state = 2;

      // looped three-word program, then loop_en cleared
      do_clr();
      for (int i = 0; i < 3; i++) load_word(16'($urandom));
      loop_en = 1'b1; instr_ready = 1'b1;
      begin_run(9);
      for (int i = 0; i < 7; i++) begin
         chk("loop_pc", {29'h0, pc}, 32'(i % 3));
         chk("loop_busy", {31'h0, busy}, 32'h1);
         tick();
      end
      loop_en = 1'b0;
      tick(); tick();
      chk("loop_done", {31'h0, done}, 32'h1);
      chk("loop_sb_empty", exp_q.size(), 32'h0);
      instr_ready = 1'b0;
      model_state = 2;

      // random programs with random backpressure
      repeat (4) begin
         do_clr();
         k = $urandom_range(1, 8);
         for (int i = 0; i < k; i++) load_word(16'($urandom));
         chk("rand_len", {28'h0, prog_len}, 32'(model_len));
         begin_run(model_len);
         finish_run();
      end

      // random looped runs ended by stop coinciding with a transfer
      repeat (3) begin
         do_clr();
         k = $urandom_range(1, 8);
         for (int i = 0; i < k; i++) load_word(16'($urandom));
         loop_en = 1'b1;
         k = $urandom_range(1, 3 * model_len);
         begin_run(k);
         cnt = 0; stopped = 1'b0;
         for (int c = 0; c < 500 && !stopped; c++) begin
            if (cnt == k - 1) begin
               instr_ready = 1'b1; stop = 1'b1;
               tick();
               stop = 1'b0; instr_ready = 1'b0; stopped = 1'b1;
            end else begin
               instr_ready = 1'($urandom_range(0, 1));
               x = instr_ready && instr_valid;
               tick();
               if (x) cnt++;
            end
         end
         chk("lstop_reached", {31'h0, stopped}, 32'h1);
         chk("lstop_busy", {31'h0, busy}, 32'h0);
         chk("lstop_valid", {31'h0, instr_valid}, 32'h0);
         chk("lstop_pc", {29'h0, pc}, 32'h0);
         chk("lstop_sb_empty", exp_q.size(), 32'h0);
         loop_en = 1'b0;
         model_state = 0;
      end

      // overflow: nine words into eight slots
      do_clr();
      for (int i = 0; i < 9; i++) load_word(16'($urandom));
      chk("ovf_len", {28'h0, prog_len}, 32'(model_len));
      chk("ovf_err", {31'h0, load_err}, {31'h0, model_err});
      begin_run(8);
      finish_run();

      // load attempted during RUN is dropped and flagged
      do_clr();
      load_word(16'($urandom)); load_word(16'($urandom));
      chk("run_err_pre", {31'h0, load_err}, 32'h0);
      begin_run(2);
      load_b(8'($urandom));
      chk("run_err", {31'h0, load_err}, {31'h0, model_err});
      finish_run();
      stop_pulse();
      chk("run_len_kept", {28'h0, prog_len}, 32'h2);
      begin_run(2);
      finish_run();
      do_clr();
      chk("clr_len", {28'h0, prog_len}, 32'h0);
      chk("clr_err", {31'h0, load_err}, 32'h0);

      // start with empty program goes straight to DONE
      begin_run(0);
      chk("empty_done", {31'h0, done}, 32'h1);
      chk("empty_valid", {31'h0, instr_valid}, 32'h0);
      tick();
      chk("empty_valid2", {31'h0, instr_valid}, 32'h0);
      stop_pulse();
      chk("empty_stop_idle", {31'h0, done}, 32'h0);

      // half-loaded word is discarded at start
      load_word(16'($urandom)); load_word(16'($urandom));
      load_b(8'hAA);
      begin_run(2);
      finish_run();
      stop_pulse();
      load_word(16'($urandom));
      chk("half_len", {28'h0, prog_len}, 32'h3);
      begin_run(3);
      finish_run();

      // stop together with the pc=1 transfer
      do_clr();
      for (int i = 0; i < 3; i++) load_word(16'($urandom));
      instr_ready = 1'b1;
      begin_run(2);
      tick();
      chk("stop_at_pc1", {29'h0, pc}, 32'h1);
      stop = 1'b1;
      tick();
      stop = 1'b0; instr_ready = 1'b0; model_state = 0;
      chk("stop_pc", {29'h0, pc}, 32'h0);
      chk("stop_valid", {31'h0, instr_valid}, 32'h0);
      chk("stop_busy", {31'h0, busy}, 32'h0);
      chk("stop_done", {31'h0, done}, 32'h0);
      chk("stop_sb_empty", exp_q.size(), 32'h0);

      // asynchronous reset in the middle of a run
      do_clr();
      for (int i = 0; i < 4; i++) load_word(16'($urandom));
      instr_ready = 1'b1;
      begin_run(4);
      tick(); tick();
      chk("mid_pc2", {29'h0, pc}, 32'h2);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_len = 0; model_phase = 0; model_err = 1'b0; model_state = 0;
      #1;
      chk("arst_valid", {31'h0, instr_valid}, 32'h0);
      chk("arst_pc", {29'h0, pc}, 32'h0);
      chk("arst_len", {28'h0, prog_len}, 32'h0);
      chk("arst_busy", {31'h0, busy}, 32'h0);
      chk("arst_instr", {16'h0, instr_out}, 32'h0);
      instr_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      begin_run(0);
      chk("post_rst_done", {31'h0, done}, 32'h1);
      chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
